// File: rtl/alu32_arbiter_pkg.sv
// Shared definitions for the two-requester ALU32 arbiter: default widths,
// ALU opcode encodings, FSM state encoding and a small one-hot helper.
package alu32_arbiter_pkg;

  localparam int unsigned ALU_WIDTH = 32;
  localparam int unsigned ALU_OPW   = 3;

  // ALU32 operation select encodings
  localparam logic [ALU_OPW-1:0] OP_AND = 3'd0;
  localparam logic [ALU_OPW-1:0] OP_OR  = 3'd1;
  localparam logic [ALU_OPW-1:0] OP_ADD = 3'd2;
  localparam logic [ALU_OPW-1:0] OP_SUB = 3'd3;
  localparam logic [ALU_OPW-1:0] OP_XOR = 3'd4;

  // Encoding 2'd3 is unused and falls back to S_IDLE
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Requester index -> one-hot two-bit vector
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu32_arbiter_rr_arb2.sv
// Two-input round-robin grant picker (purely combinational).
// Ports:
//   Req [1:0] : request vector, bit i = requester i
//   Ptr       : favoured requester this round
//   Gnt [1:0] : one-hot grant, zero when no request
module rr_arb2 (
  input  logic [1:0] Req,
  input  logic       Ptr,
  output logic [1:0] Gnt
);

  always_comb begin
    Gnt = 2'b00;
    if (Ptr == 1'b0) begin
      if (Req[0])      Gnt = 2'b01;
      else if (Req[1]) Gnt = 2'b10;
    end else begin
      if (Req[1])      Gnt = 2'b10;
      else if (Req[0]) Gnt = 2'b01;
    end
  end

endmodule

// File: rtl/alu32_arbiter.sv
// Shares one external combinational ALU32 between two requesters.
// Round-robin grant, registered operands, one settle cycle, then a held
// response until the owning requester consumes it.
// Ports:
//   Clk, Rst_n           : clock, asynchronous active-low reset
//   Req_Valid/Req_Ready  : per-requester request handshake (Req_Ready combinational)
//   Req_Op/Req_A/Req_B   : packed per-requester opcode and operands
//   Rsp_Valid/Rsp_Ready  : per-requester response handshake
//   Rsp_Data             : shared result bus, qualified by Rsp_Valid
//   Alu_Op/In1/In2       : registered drive into the ALU32
//   Alu_Out              : ALU32 result
//   Busy                 : high while an operation is in flight
module alu32_arbiter
  import alu32_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned OPW   = ALU_OPW
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic [1:0]           Req_Valid,
  output logic [1:0]           Req_Ready,
  input  logic [2*OPW-1:0]     Req_Op,
  input  logic [2*WIDTH-1:0]   Req_A,
  input  logic [2*WIDTH-1:0]   Req_B,
  output logic [1:0]           Rsp_Valid,
  input  logic [1:0]           Rsp_Ready,
  output logic [WIDTH-1:0]     Rsp_Data,
  output logic [OPW-1:0]       Alu_Op,
  output logic [WIDTH-1:0]     Alu_In1,
  output logic [WIDTH-1:0]     Alu_In2,
  input  logic [WIDTH-1:0]     Alu_Out,
  output logic                 Busy
);

  state_t     state, state_nxt;
  logic       rr_ptr;
  logic       gnt_id;
  logic [1:0] gnt_c;
  logic       load_c, capture_c, release_c;

  rr_arb2 u_arb (
    .Req (Req_Valid),
    .Ptr (rr_ptr),
    .Gnt (gnt_c)
  );

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state, request acceptance and datapath enables
  always_comb begin
    state_nxt = state;
    Req_Ready = 2'b00;
    load_c    = 1'b0;
    capture_c = 1'b0;
    release_c = 1'b0;
    case (state)
      S_IDLE: begin
        // Gated by reset so Req_Ready reads zero while held in reset
        if (Rst_n && (|Req_Valid)) begin
          Req_Ready = gnt_c;
          load_c    = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        capture_c = 1'b1;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        if (Rsp_Ready[gnt_id]) begin
          release_c = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, result capture and response hold
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Alu_Op    <= '0;
      Alu_In1   <= '0;
      Alu_In2   <= '0;
      Rsp_Data  <= '0;
      Rsp_Valid <= 2'b00;
      gnt_id    <= 1'b0;
      rr_ptr    <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      Busy <= (state_nxt != S_IDLE);
      if (load_c) begin
        Alu_Op  <= gnt_c[1] ? Req_Op[OPW +: OPW]     : Req_Op[0 +: OPW];
        Alu_In1 <= gnt_c[1] ? Req_A[WIDTH +: WIDTH]  : Req_A[0 +: WIDTH];
        Alu_In2 <= gnt_c[1] ? Req_B[WIDTH +: WIDTH]  : Req_B[0 +: WIDTH];
        gnt_id  <= gnt_c[1];
        rr_ptr  <= ~gnt_c[1];
      end
      if (capture_c) begin
        Rsp_Data  <= Alu_Out;
        Rsp_Valid <= onehot2(gnt_id);
      end
      if (release_c) begin
        Rsp_Valid <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_alu32_arbiter.sv
// Self-checking bench for alu32_arbiter: directed scenarios plus random
// traffic, all checked every cycle against a transaction-level model.
module tb_alu32_arbiter;
  import alu32_arbiter_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [1:0]  Req_Valid;
  logic [1:0]  Req_Ready;
  logic [5:0]  Req_Op;
  logic [63:0] Req_A;
  logic [63:0] Req_B;
  logic [1:0]  Rsp_Valid;
  logic [1:0]  Rsp_Ready;
  logic [31:0] Rsp_Data;
  logic [2:0]  Alu_Op;
  logic [31:0] Alu_In1;
  logic [31:0] Alu_In2;
  logic [31:0] Alu_Out;
  logic        Busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference ALU behaviour
  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a + b;
      3'd3:    return a - b;
      3'd4:    return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  assign Alu_Out = alu_ref(Alu_Op, Alu_In1, Alu_In2);

  alu32_arbiter dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Req_Valid(Req_Valid), .Req_Ready(Req_Ready),
    .Req_Op(Req_Op), .Req_A(Req_A), .Req_B(Req_B),
    .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready), .Rsp_Data(Rsp_Data),
    .Alu_Op(Alu_Op), .Alu_In1(Alu_In1), .Alu_In2(Alu_In2), .Alu_Out(Alu_Out),
    .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding op with an age in edges
  logic        m_pending;
  int          m_age;
  logic        m_owner;
  logic        m_ptr;
  logic [31:0] m_res, m_data, m_a, m_b;
  logic [2:0]  m_op;
  logic [1:0]  acc;
  logic [1:0]  s_rr, s_rv;
  logic [31:0] s_rd;

  task automatic model_reset();
    m_pending = 1'b0; m_age = 0; m_owner = 1'b0; m_ptr = 1'b0;
    m_res = '0; m_data = '0; m_a = '0; m_b = '0; m_op = '0; acc = '0;
  endtask

  function automatic logic [2:0]  op_of(input logic i); return i ? Req_Op[5:3]   : Req_Op[2:0];  endfunction
  function automatic logic [31:0] a_of (input logic i); return i ? Req_A[63:32] : Req_A[31:0]; endfunction
  function automatic logic [31:0] b_of (input logic i); return i ? Req_B[63:32] : Req_B[31:0]; endfunction

  // Sample and check on the falling edge, advance the model, return at posedge+1
  task automatic step();
    logic [1:0] g;
    logic [1:0] exp_rv;
    @(negedge Clk);
    s_rr = Req_Ready; s_rv = Rsp_Valid; s_rd = Rsp_Data;
    g = 2'b00;
    if (!m_pending && (Req_Valid != 2'b00)) begin
      if (Req_Valid[m_ptr]) g = onehot2(m_ptr);
      else                  g = onehot2(~m_ptr);
    end
    exp_rv = (m_pending && m_age == 2) ? onehot2(m_owner) : 2'b00;
    check("req_ready", 32'(Req_Ready), 32'(g));
    check("rsp_valid", 32'(Rsp_Valid), 32'(exp_rv));
    check("rsp_data",  Rsp_Data, m_data);
    check("busy",      32'(Busy), 32'(m_pending));
    check("alu_op",    32'(Alu_Op), 32'(m_op));
    check("alu_in1",   Alu_In1, m_a);
    check("alu_in2",   Alu_In2, m_b);
    acc = g;
    if (!m_pending) begin
      if (g != 2'b00) begin
        m_owner   = g[1];
        m_op      = op_of(m_owner);
        m_a       = a_of(m_owner);
        m_b       = b_of(m_owner);
        m_res     = alu_ref(m_op, m_a, m_b);
        m_ptr     = ~m_owner;
        m_pending = 1'b1;
        m_age     = 1;
      end
    end else if (m_age == 1) begin
      m_age  = 2;
      m_data = m_res;
    end else if (Rsp_Ready[m_owner]) begin
      m_pending = 1'b0;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    Req_Valid[i]     = 1'b1;
    Req_Op[i*3 +: 3] = op;
    Req_A[i*32 +: 32] = a;
    Req_B[i*32 +: 32] = b;
  endtask

  // Assert reset (called at posedge+1), check outputs, release two cycles later
  task automatic do_reset(input bit chk_zero);
    Rst_n = 1'b0;
    #1;
    if (chk_zero) begin
      check("rst_req_ready", 32'(Req_Ready), 32'd0);
      check("rst_rsp_valid", 32'(Rsp_Valid), 32'd0);
      check("rst_rsp_data",  Rsp_Data, 32'd0);
      check("rst_alu_op",    32'(Alu_Op), 32'd0);
      check("rst_alu_in1",   Alu_In1, 32'd0);
      check("rst_alu_in2",   Alu_In2, 32'd0);
      check("rst_busy",      32'(Busy), 32'd0);
    end
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    Rst_n = 1'b1;
  endtask

  task automatic drain();
    Req_Valid = 2'b00;
    Rsp_Ready = 2'b11;
    for (int k = 0; k < 8 && m_pending; k++) step();
    check("drain_timeout", 32'(Busy), 32'd0);
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 4))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0000_0000;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] rsp_dat_q[$];
  logic [1:0]  rsp_who_q[$];
  logic        gnt_q[$];
  int          cyc, prev, gaps;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst_n = 1'b0; Req_Valid = '0; Req_Op = '0; Req_A = '0; Req_B = '0; Rsp_Ready = '0;
    model_reset();
    @(posedge Clk); #1;
    do_reset(1'b1);

    // Reset in the middle of an operation
    set_req(0, OP_ADD, 32'd1, 32'd2);
    step();
    Req_Valid = 2'b00;
    check("exec_busy", 32'(Busy), 32'd1);
    do_reset(1'b1);
    set_req(0, OP_AND, 32'h1234_5678, 32'h0F0F_0F0F);
    set_req(1, OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000);
    step();
    check("rst_first_grant", 32'(s_rr), 32'd1);
    drain();

    // Single OR operation, two-edge latency
    Rsp_Ready = 2'b00;
    set_req(0, OP_OR, 32'hF0F0_0000, 32'h0000_0F0F);
    step();
    check("single_accept", 32'(s_rr), 32'd1);
    Req_Valid = 2'b00;
    step();
    check("single_exec_no_rsp", 32'(s_rv), 32'd0);
    step();
    check("single_rsp_valid", 32'(s_rv), 32'd1);
    check("single_rsp_data", s_rd, 32'hF0F0_0F0F);
    drain();

    // Contention from reset: strict alternation
    do_reset(1'b0);
    Rst_n = 1'b0;
    set_req(0, OP_ADD, 32'd5, 32'd7);
    set_req(1, OP_AND, 32'h0000_00FF, 32'h0000_000F);
    Rsp_Ready = 2'b11;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (s_rr != 2'b00) gnt_q.push_back(s_rr[1]);
      if (s_rv != 2'b00) begin rsp_who_q.push_back(s_rv); rsp_dat_q.push_back(s_rd); end
    end
    check("cont_ngrants", 32'(gnt_q.size()), 32'd4);
    check("cont_nrsp", 32'(rsp_dat_q.size()), 32'd4);
    if (gnt_q.size() >= 4) begin
      for (int k = 0; k < 4; k++) check("cont_grant_order", 32'(gnt_q[k]), 32'(k % 2));
    end
    if (rsp_dat_q.size() >= 2) begin
      check("cont_rsp0_who", 32'(rsp_who_q[0]), 32'd1);
      check("cont_rsp0_data", rsp_dat_q[0], 32'd12);
      check("cont_rsp1_who", 32'(rsp_who_q[1]), 32'd2);
      check("cont_rsp1_data", rsp_dat_q[1], 32'h0000_000F);
    end
    drain();

    // Backpressure: response held, other requester's ready ignored
    Rsp_Ready = 2'b10;
    set_req(0, OP_SUB, 32'd100, 32'd1);
    step();
    Req_Valid[0] = 1'b0;
    set_req(1, OP_XOR, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    step();
    for (int k = 0; k < 10; k++) begin
      step();
      check("bp_rsp_valid", 32'(s_rv), 32'd1);
      check("bp_rsp_data", s_rd, 32'd99);
      check("bp_req_ready", 32'(s_rr), 32'd0);
      check("bp_busy", 32'(Busy), 32'd1);
    end
    Rsp_Ready = 2'b01;
    step();
    step();
    check("bp_next_grant", 32'(s_rr), 32'd2);
    Req_Valid = 2'b00;
    drain();

    // Throughput: one grant every third cycle
    set_req(1, OP_ADD, 32'd3, 32'd4);
    Rsp_Ready = 2'b11;
    cyc = 0; prev = -1; gaps = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (s_rr[1]) begin
        if (prev >= 0) begin check("thru_gap", 32'(cyc - prev), 32'd3); gaps++; end
        prev = cyc;
      end
      cyc++;
    end
    check("thru_count", 32'(gaps), 32'd9);
    drain();

    // Adder wrap-around
    Rsp_Ready = 2'b00;
    set_req(0, OP_ADD, 32'hFFFF_FFFF, 32'd1);
    step();
    Req_Valid = 2'b00;
    step();
    step();
    check("wrap_rsp_valid", 32'(s_rv), 32'd1);
    check("wrap_rsp_data", s_rd, 32'h0000_0000);
    drain();

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        if (Req_Valid[i] && acc[i]) begin
          Req_Valid[i] = 1'b0;
          if ($urandom_range(0, 1) == 1)
            set_req(i, 3'($urandom_range(0, 4)), rand_word(), rand_word());
        end else if (!Req_Valid[i] && $urandom_range(0, 9) < 4) begin
          set_req(i, 3'($urandom_range(0, 4)), rand_word(), rand_word());
        end
      end
      Rsp_Ready = 2'($urandom_range(0, 3));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
